// File: rtl/call_controller.sv
// Call-control engine: turns UI commands into signalling packets, received
// packets into UI status, and owns the call FSM, ring timeout and audio gate.
module call_controller #(
  parameter logic [7:0]      MY_ADDR      = 8'h01,
  parameter int unsigned     TO_W         = 27,
  parameter logic [TO_W-1:0] RING_TIMEOUT = TO_W'(81000000)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] command,
  input  logic [7:0] phn_num,
  output logic [3:0] inc_command,
  output logic [7:0] inc_address,
  output logic       net_tx_valid,
  input  logic       net_tx_ready,
  output logic [2:0] net_tx_type,
  output logic [7:0] net_tx_dst,
  input  logic       net_rx_valid,
  input  logic [2:0] net_rx_type,
  input  logic [7:0] net_rx_src,
  input  logic [7:0] net_rx_dst,
  output logic       audio_en
);

  localparam logic [4:0] CMD_DIAL   = 5'd1;
  localparam logic [4:0] CMD_ACCEPT = 5'd2;
  localparam logic [4:0] CMD_REJECT = 5'd3;
  localparam logic [4:0] CMD_END    = 5'd4;

  localparam logic [2:0] PKT_CALL_REQ = 3'd1;
  localparam logic [2:0] PKT_ACCEPT   = 3'd2;
  localparam logic [2:0] PKT_REJECT   = 3'd3;
  localparam logic [2:0] PKT_HANGUP   = 3'd4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DIALING   = 4'd1;
  localparam logic [3:0] ST_CONNECTED = 4'd2;
  localparam logic [3:0] ST_REJECTED  = 4'd3;
  localparam logic [3:0] ST_NOANSWER  = 4'd4;
  localparam logic [3:0] ST_INCOMING  = 4'd6;

  localparam logic [TO_W-1:0] TO_LAST = RING_TIMEOUT - TO_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DIALING, S_RINGING, S_CONNECTED} state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]      prev_cmd_q, prev_cmd_d;
  logic [3:0]      inc_command_q, inc_command_d;
  logic [7:0]      inc_address_q, inc_address_d;
  logic            tx_valid_q, tx_valid_d;
  logic [2:0]      tx_type_q, tx_type_d;
  logic [7:0]      tx_dst_q, tx_dst_d;
  logic            audio_en_q, audio_en_d;

  logic       load_ok, cmd_new, rx_ok, rx_peer, rx_other, timeout;
  logic       send;
  logic [2:0] send_type;
  logic [7:0] send_dst;

  always_comb begin
    load_ok  = !tx_valid_q;
    cmd_new  = load_ok && (command != prev_cmd_q) && (command != 5'd0);
    rx_ok    = net_rx_valid && (net_rx_dst == MY_ADDR);
    rx_peer  = rx_ok && (net_rx_src == inc_address_q);
    rx_other = rx_ok && (net_rx_src != inc_address_q) && (net_rx_type == PKT_CALL_REQ);
    // >= so a timeout pre-empted by an rx event still fires next cycle
    timeout  = (cnt_q >= TO_LAST);

    state_d       = state_q;
    prev_cmd_d    = command;
    inc_command_d = inc_command_q;
    inc_address_d = inc_address_q;
    cnt_d         = (state_q == S_DIALING || state_q == S_RINGING) ? cnt_q + TO_W'(1) : cnt_q;
    send          = 1'b0;
    send_type     = 3'd0;
    send_dst      = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (cmd_new && command == CMD_DIAL) begin
          send = 1'b1; send_type = PKT_CALL_REQ; send_dst = phn_num;
          inc_address_d = phn_num;
          inc_command_d = ST_DIALING;
          cnt_d         = '0;
          state_d       = S_DIALING;
        end else if (rx_ok && net_rx_type == PKT_CALL_REQ) begin
          inc_address_d = net_rx_src;
          inc_command_d = ST_INCOMING;
          cnt_d         = '0;
          state_d       = S_RINGING;
        end
      end
      S_DIALING: begin
        if (cmd_new && command == CMD_END) begin
          send = 1'b1; send_type = PKT_HANGUP; send_dst = inc_address_q;
          inc_command_d = ST_IDLE;
          state_d       = S_IDLE;
        end else if (rx_peer && net_rx_type == PKT_ACCEPT) begin
          inc_command_d = ST_CONNECTED;
          state_d       = S_CONNECTED;
        end else if (rx_peer && net_rx_type == PKT_REJECT) begin
          inc_command_d = ST_REJECTED;
          state_d       = S_IDLE;
        end else if (timeout) begin
          send = 1'b1; send_type = PKT_HANGUP; send_dst = inc_address_q;
          inc_command_d = ST_NOANSWER;
          state_d       = S_IDLE;
        end
      end
      S_RINGING: begin
        if (cmd_new && command == CMD_ACCEPT) begin
          send = 1'b1; send_type = PKT_ACCEPT; send_dst = inc_address_q;
          inc_command_d = ST_CONNECTED;
          state_d       = S_CONNECTED;
        end else if (cmd_new && (command == CMD_REJECT || command == CMD_END)) begin
          send = 1'b1; send_type = PKT_REJECT; send_dst = inc_address_q;
          inc_command_d = ST_IDLE;
          state_d       = S_IDLE;
        end else if (rx_peer && net_rx_type == PKT_HANGUP) begin
          inc_command_d = ST_IDLE;
          state_d       = S_IDLE;
        end else if (rx_other) begin
          send = 1'b1; send_type = PKT_REJECT; send_dst = net_rx_src;
        end else if (timeout) begin
          send = 1'b1; send_type = PKT_REJECT; send_dst = inc_address_q;
          inc_command_d = ST_NOANSWER;
          state_d       = S_IDLE;
        end
      end
      S_CONNECTED: begin
        if (cmd_new && command == CMD_END) begin
          send = 1'b1; send_type = PKT_HANGUP; send_dst = inc_address_q;
          inc_command_d = ST_IDLE;
          state_d       = S_IDLE;
        end else if (rx_peer && net_rx_type == PKT_HANGUP) begin
          inc_command_d = ST_IDLE;
          state_d       = S_IDLE;
        end else if (rx_other) begin
          send = 1'b1; send_type = PKT_REJECT; send_dst = net_rx_src;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Packet slot: a pending packet holds until accepted; a new one loads only
    // into an empty slot, otherwise it is lost while the FSM still moves on.
    tx_valid_d = tx_valid_q;
    tx_type_d  = tx_type_q;
    tx_dst_d   = tx_dst_q;
    if (tx_valid_q && net_tx_ready) tx_valid_d = 1'b0;
    if (send && load_ok) begin
      tx_valid_d = 1'b1;
      tx_type_d  = send_type;
      tx_dst_d   = send_dst;
    end

    audio_en_d = (state_d == S_CONNECTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      prev_cmd_q    <= '0;
      inc_command_q <= '0;
      inc_address_q <= '0;
      tx_valid_q    <= 1'b0;
      tx_type_q     <= '0;
      tx_dst_q      <= '0;
      audio_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_cmd_q    <= prev_cmd_d;
      inc_command_q <= inc_command_d;
      inc_address_q <= inc_address_d;
      tx_valid_q    <= tx_valid_d;
      tx_type_q     <= tx_type_d;
      tx_dst_q      <= tx_dst_d;
      audio_en_q    <= audio_en_d;
    end
  end

  assign inc_command  = inc_command_q;
  assign inc_address  = inc_address_q;
  assign net_tx_valid = tx_valid_q;
  assign net_tx_type  = tx_type_q;
  assign net_tx_dst   = tx_dst_q;
  assign audio_en     = audio_en_q;

endmodule

// File: tb/tb_call_controller.sv
// Directed bench for call_controller: expected packets go into a scoreboard
// queue, a negedge monitor checks each handshake plus hold stability.
module tb_call_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] command;
  logic [7:0] phn_num;
  logic [3:0] inc_command;
  logic [7:0] inc_address;
  logic       net_tx_valid;
  logic       net_tx_ready;
  logic [2:0] net_tx_type;
  logic [7:0] net_tx_dst;
  logic       net_rx_valid;
  logic [2:0] net_rx_type;
  logic [7:0] net_rx_src;
  logic [7:0] net_rx_dst;
  logic       audio_en;

  call_controller #(.MY_ADDR(8'h01), .TO_W(27), .RING_TIMEOUT(27'd10)) dut (
    .clk(clk), .reset(reset), .command(command), .phn_num(phn_num),
    .inc_command(inc_command), .inc_address(inc_address),
    .net_tx_valid(net_tx_valid), .net_tx_ready(net_tx_ready),
    .net_tx_type(net_tx_type), .net_tx_dst(net_tx_dst),
    .net_rx_valid(net_rx_valid), .net_rx_type(net_rx_type),
    .net_rx_src(net_rx_src), .net_rx_dst(net_rx_dst), .audio_en(audio_en)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] t; logic [7:0] d; } pkt_t;
  pkt_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted packet must match the head of the scoreboard,
  // and a stalled packet must keep type/dst until it is taken.
  logic hold_v = 1'b0;
  pkt_t hold_p;
  always @(negedge clk) begin
    pkt_t exp;
    if (net_tx_valid === 1'b1) begin
      if (hold_v) chk("tx_stable", {net_tx_type, net_tx_dst}, hold_p);
      if (net_tx_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got type %0d dst %0h, none queued", net_tx_type, net_tx_dst);
        end else begin
          exp = sb.pop_front();
          chk("tx_pkt", {net_tx_type, net_tx_dst}, exp);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_p = {net_tx_type, net_tx_dst};
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx(input logic [2:0] t, input logic [7:0] src, input logic [7:0] dst);
    net_rx_valid = 1'b1; net_rx_type = t; net_rx_src = src; net_rx_dst = dst;
  endtask

  task automatic rx_clr();
    net_rx_valid = 1'b0; net_rx_type = 3'd0; net_rx_src = 8'd0; net_rx_dst = 8'd0;
  endtask

  initial begin
    reset = 1'b1; command = 5'd0; phn_num = 8'd0; net_tx_ready = 1'b1;
    rx_clr();
    tick(2);
    chk("rst_inc_cmd", inc_command, 0);
    chk("rst_inc_addr", inc_address, 0);
    chk("rst_tx", {net_tx_valid, net_tx_type, net_tx_dst}, 0);
    chk("rst_audio", audio_en, 0);
    reset = 1'b0;
    tick();

    // Dial 04 with a 3-cycle ready stall, peer accepts, local hangup
    net_tx_ready = 1'b0;
    command = 5'd1; phn_num = 8'h04; sb.push_back('{3'd1, 8'h04});
    tick();
    chk("dial_tx", {net_tx_valid, net_tx_type, net_tx_dst}, {1'b1, 3'd1, 8'h04});
    chk("dial_inc", {inc_command, inc_address}, {4'd1, 8'h04});
    command = 5'd0;
    tick(3);
    chk("dial_stall_valid", net_tx_valid, 1);
    net_tx_ready = 1'b1;
    tick();
    chk("dial_valid_drop", net_tx_valid, 0);
    rx(3'd2, 8'h04, 8'h01);
    tick(); rx_clr();
    chk("conn_inc", inc_command, 2);
    chk("conn_audio", audio_en, 1);
    command = 5'd4; sb.push_back('{3'd4, 8'h04});
    tick();
    chk("end_inc", inc_command, 0);
    chk("end_audio", audio_en, 0);
    command = 5'd0;
    tick();

    // Incoming call from 07, accept, remote hangup
    rx(3'd1, 8'h07, 8'h01);
    tick(); rx_clr();
    chk("ring_inc", {inc_command, inc_address}, {4'd6, 8'h07});
    command = 5'd2; sb.push_back('{3'd2, 8'h07});
    tick();
    chk("acc_inc", inc_command, 2);
    chk("acc_audio", audio_en, 1);
    command = 5'd0;
    tick();
    rx(3'd4, 8'h07, 8'h01);
    tick(); rx_clr();
    chk("rhang_inc", inc_command, 0);
    chk("rhang_audio", audio_en, 0);

    // Foreign dst ignored; held dial acts once; no answer times out
    rx(3'd1, 8'h05, 8'h02);
    tick(); rx_clr();
    chk("wrong_dst", {inc_command, inc_address}, {4'd0, 8'h07});
    command = 5'd1; phn_num = 8'h04; sb.push_back('{3'd1, 8'h04});
    tick(5);
    command = 5'd0;
    tick(5);
    chk("to_before", {inc_command, net_tx_valid}, {4'd1, 1'b0});
    sb.push_back('{3'd4, 8'h04});
    tick();
    chk("to_tx", {net_tx_valid, net_tx_type, net_tx_dst}, {1'b1, 3'd4, 8'h04});
    chk("to_inc", inc_command, 4);
    tick();

    // Connected with 04: busy reject to 09, then end + rx hangup together
    command = 5'd1; phn_num = 8'h04; sb.push_back('{3'd1, 8'h04});
    tick(); command = 5'd0;
    tick();
    rx(3'd2, 8'h04, 8'h01);
    tick();
    chk("c2_inc", inc_command, 2);
    rx(3'd1, 8'h09, 8'h01); sb.push_back('{3'd3, 8'h09});
    tick(); rx_clr();
    chk("busy_inc", inc_command, 2);
    chk("busy_tx", {net_tx_valid, net_tx_type, net_tx_dst}, {1'b1, 3'd3, 8'h09});
    tick();
    command = 5'd4; rx(3'd4, 8'h04, 8'h01); sb.push_back('{3'd4, 8'h04});
    tick(); rx_clr(); command = 5'd0;
    chk("both_inc", {inc_command, audio_en}, {4'd0, 1'b0});
    tick(2);
    chk("both_one_pkt", net_tx_valid, 0);

    // Reset while a hangup is pending in CONNECTED: packet abandoned
    command = 5'd1; phn_num = 8'h04; sb.push_back('{3'd1, 8'h04});
    tick(); command = 5'd0;
    tick();
    rx(3'd2, 8'h04, 8'h01);
    tick(); rx_clr();
    net_tx_ready = 1'b0; command = 5'd4;
    tick();
    chk("pre_rst_valid", net_tx_valid, 1);
    reset = 1'b1; command = 5'd0;
    tick();
    chk("mid_rst_out", {inc_command, inc_address, net_tx_valid, net_tx_type, net_tx_dst, audio_en}, 0);
    reset = 1'b0; net_tx_ready = 1'b1;
    tick(3);
    chk("post_rst_valid", net_tx_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/call_controller.md
Name: call_controller

Overview:
- Application-layer call-control engine; the peer of user_interface.
- Consumes the UI's `command`/`phn_num` strobes and drives the UI's `inc_command`/`inc_address` status inputs.
- Converts local intents into call-signalling packets on a valid/ready network port, and network packets back into UI status.
- Owns the call state machine, the ring/dial timeout and the audio-path enable.

Parameters:
- MY_ADDR, 8'h01, this station's address; received packets with other dst are ignored.
- RING_TIMEOUT, 27'd81000000, cycles to wait in DIALING or RINGING before giving up (~3 s @ 27 MHz).
- TO_W, 27, width of the timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- command  in  5  UI request: 0 none, 1 dial phn_num, 2 accept, 3 reject, 4 end call; others ignored
- phn_num  in  8  destination address, sampled with a dial command
- inc_command  out  4  status to UI, held level: 0 idle/ended, 1 dialing, 2 connected, 3 rejected, 4 no answer, 6 incoming call
- inc_address  out  8  peer address for the current or last call
- net_tx_valid  out  1  packet offered
- net_tx_ready  in  1  network accepts the packet when valid&ready
- net_tx_type  out  3  1 CALL_REQ, 2 ACCEPT, 3 REJECT, 4 HANGUP
- net_tx_dst  out  8  packet destination
- net_rx_valid  in  1  one-cycle received-packet strobe
- net_rx_type  in  3  same encoding as net_tx_type
- net_rx_src  in  8  sender address
- net_rx_dst  in  8  addressee
- audio_en  out  1  1 only in CONNECTED

Behaviour:
- Reset values: inc_command=0, inc_address=0, net_tx_valid=0, net_tx_type=0, net_tx_dst=0, audio_en=0, state IDLE, timeout counter 0, prev_command=0.
- Command edge detect: a command is accepted only in a cycle where command≠prev_command and command≠0. A held level acts once.
- Rx filter: a packet is valid when net_rx_valid=1 and net_rx_dst==MY_ADDR; otherwise it is ignored.
- TX handshake:
  - Loading a packet sets net_tx_valid=1 with type/dst.
  - type/dst stay stable until the cycle valid&ready is high; valid drops the next cycle.
  - While net_tx_valid=1, UI commands are dropped and no new packet is loaded. State transitions still proceed.
- States and transitions (outputs registered, update one cycle after the trigger):
  - IDLE:
    - dial → send CALL_REQ to phn_num; inc_address=phn_num; inc_command=1; counter clear; go DIALING.
    - rx CALL_REQ → inc_address=src; inc_command=6; counter clear; go RINGING.
    - Other rx types ignored. inc_command keeps its last value (0, 3 or 4) until the next event.
  - DIALING (counter increments each cycle):
    - rx ACCEPT from inc_address → inc_command=2; go CONNECTED.
    - rx REJECT from inc_address → inc_command=3; go IDLE.
    - end → send HANGUP; inc_command=0; go IDLE.
    - counter==RING_TIMEOUT-1 → send HANGUP; inc_command=4; go IDLE.
  - RINGING (counter increments each cycle):
    - accept → send ACCEPT; inc_command=2; go CONNECTED.
    - reject or end → send REJECT; inc_command=0; go IDLE.
    - rx HANGUP from inc_address → inc_command=0; go IDLE.
    - timeout → send REJECT; inc_command=4; go IDLE.
    - rx CALL_REQ from another source → reply REJECT to that source; stay in RINGING.
  - CONNECTED (audio_en=1):
    - end → send HANGUP; inc_command=0; go IDLE.
    - rx HANGUP from inc_address → inc_command=0; go IDLE.
    - rx CALL_REQ from another source → reply REJECT (busy).
- Precedence:
  - A local command and an rx event in the same cycle: local command wins; the rx event is discarded.
  - Timeout and an rx event in the same cycle: rx wins.
- Peer match: packets from a source other than inc_address are ignored in DIALING and CONNECTED, except the CALL_REQ busy reply.
- Dial to own address: allowed, no special case.
- Reset mid-call: immediate return to reset values. Any pending tx is abandoned; no HANGUP is sent.

Test Plan:
- Reset, then dial: command=1 with phn_num=8'h04 → net_tx_valid=1, type=1, dst=04; hold ready=0 for 3 cycles and type/dst stay stable; ready=1 → valid low next cycle; inc_command=1, inc_address=04.
- Dialing, rx ACCEPT src=04 dst=01 → inc_command=2, audio_en=1. Then command=4 → HANGUP to 04, inc_command=0, audio_en=0.
- Rx CALL_REQ src=07 → inc_command=6, inc_address=07. Command=2 → ACCEPT to 07, inc_command=2. Rx HANGUP src=07 → inc_command=0.
- RING_TIMEOUT=10, dial and no reply → exactly 10 cycles after entering DIALING a HANGUP is sent and inc_command=4. Also: rx with dst=02 is ignored, and command held at 1 for 5 cycles produces only one CALL_REQ.
- Connected with 04, rx CALL_REQ src=09 → REJECT to 09; inc_command stays 2. Same cycle: command=4 plus rx HANGUP src=04 → one HANGUP sent, state IDLE.
- Reset asserted while net_tx_valid=1 in CONNECTED → next cycle all outputs 0, no packet completes.
